ram64_fifo_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 15 +
 rtl/rr_arb2.sv | 34 +++
 rtl/ram64_fifo_ctrl.sv | 88 ++++++++
 tb/tb_ram64_fifo_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and grant encoding for the ram64 FIFO controller.
package fifo_pkg;

    localparam int WIDTH = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;
    localparam int LVL_W = 7;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter for the shared RAM port; rr flips on every conflict
// so neither reads nor writes can starve.
module rr_arb2
    import fifo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic       wr_req,
    output logic [1:0] gnt
);

    logic rr;

    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = GNT_NONE;
        if (rd_req && wr_req)
            gnt = rr ? GNT_WR : GNT_RD;
        else if (rd_req)
            gnt = GNT_RD;
        else if (wr_req)
            gnt = GNT_WR;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking for all clocked state so every flop samples pre-edge values.
        if (reset)
            rr <= 1'b0;
        else if (rd_req && wr_req)
            rr <= ~rr;
    end

endmodule

// File: rtl/ram64_fifo_ctrl.sv
// Turns the single-port 64x16 ram64 into a 65-entry FIFO: 64 RAM words plus
// one registered head word, arbitrating writes against prefetch reads.
module ram64_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH  = fifo_pkg::WIDTH,
    parameter int AW     = fifo_pkg::AW,
    parameter int AF_LVL = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [6:0]       level,
    output logic             almost_full,
    output logic [AW-1:0]    ram_adr,
    output logic [WIDTH-1:0] ram_data,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out
);

    localparam int RAM_WORDS = 2 ** AW;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] ram_cnt;
    logic             ram_full;
    logic             ram_empty;
    logic             rd_req;
    logic             wr_req;
    logic [1:0]       gnt;
    logic             wr_gnt;
    logic             rd_gnt;
    logic             pop;

    assign ram_full  = (ram_cnt == LVL_W'(RAM_WORDS));
    assign ram_empty = (ram_cnt == '0);
    assign pop       = out_valid & out_ready;

    // Requests are masked during reset so the RAM is never written then.
    assign rd_req = ~reset & ~ram_empty & (~out_valid | out_ready);
    assign wr_req = ~reset & in_valid & ~ram_full;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .rd_req (rd_req),
        .wr_req (wr_req),
        .gnt    (gnt)
    );

    assign wr_gnt = (gnt == GNT_WR);
    assign rd_gnt = (gnt == GNT_RD);

    assign ram_load = wr_gnt;
    assign ram_adr  = wr_gnt ? wr_ptr : rd_ptr;
    assign ram_data = in_data;
    assign in_ready = ~reset & ~ram_full & ~rd_gnt;

    assign level       = ram_cnt + LVL_W'(out_valid);
    assign almost_full = (level >= LVL_W'(AF_LVL));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_gnt)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_gnt) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_data  <= ram_out;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            ram_cnt <= ram_cnt + LVL_W'(wr_gnt) - LVL_W'(rd_gnt);
        end
    end

endmodule

// File: tb/tb_ram64_fifo_ctrl.sv
// Scoreboard bench for ram64_fifo_ctrl paired with a behavioural 64x16 RAM.
module tb_ram64_fifo_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [6:0]  level;
    logic        almost_full;
    logic [5:0]  ram_adr;
    logic [15:0] ram_data;
    logic        ram_load;
    logic [15:0] ram_out;

    logic [15:0] mem [64];

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    ram64_fifo_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full),
        .ram_adr     (ram_adr),
        .ram_data    (ram_data),
        .ram_load    (ram_load),
        .ram_out     (ram_out)
    );

    // ram64: combinational read, write on the rising edge when load is high
    assign ram_out = mem[ram_adr];
    always @(posedge clk)
        if (ram_load)
            mem[ram_adr] <= ram_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, record accepted pushes just before the rising edge
    task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy,
                         input logic rst, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        reset     = rst;
        #4;
        acc = !rst && iv && in_ready;
        if (rst)
            exp_q.delete();
        else if (acc)
            exp_q.push_back(d);
    endtask

    task automatic drain(input string name);
        logic acc;
        for (int i = 0; i < 400 && exp_q.size() > 0; i++)
            cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops the model whenever the consumer takes a word
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                check("ram_load_in_reset", int'(ram_load), 0);
                check("in_ready_in_reset", int'(in_ready), 0);
            end else begin
                check("level", int'(level), exp_q.size());
                check("almost_full", int'(almost_full), int'(exp_q.size() >= 60));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_unexpected: got=%0h want=no_word", out_data);
                    end else begin
                        check("out_data", int'(out_data), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        logic prev_load;
        int   nxt;
        int   pv;
        int   pr;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;

        // 1: reset state and single-word latency
        cycle(1'b0, 16'h0, 1'b0, 1'b1, acc);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, acc);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        check("reset_level", int'(level), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        cycle(1'b1, 16'h1234, 1'b1, 1'b0, acc);
        check("t1_accept", int'(acc), 1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        check("t1_n1_out_valid", int'(out_valid), 0);
        check("t1_n1_level", int'(level), 1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        check("t1_n2_out_valid", int'(out_valid), 1);
        check("t1_n2_out_data", int'(out_data), 16'h1234);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        check("t1_n3_level", int'(level), 0);

        // 2: fill to 65 words with the consumer stalled
        nxt = 0;
        for (int i = 0; i < 400 && nxt < 65; i++) begin
            cycle(1'b1, 16'(nxt), 1'b0, 1'b0, acc);
            if (acc) nxt++;
        end
        check("t2_pushed", nxt, 65);
        cycle(1'b1, 16'h0041, 1'b0, 1'b0, acc);
        check("t2_full_in_ready", int'(in_ready), 0);
        check("t2_full_level", int'(level), 65);
        check("t2_full_almost_full", int'(almost_full), 1);

        // 3: drain in order across the pointer wrap
        drain("t3_drained");

        // 4: streaming with constant contention alternates grants
        nxt = 16'h0100;
        prev_load = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 16'(nxt), 1'b1, 1'b0, acc);
            if (acc) nxt++;
            if (i >= 10)
                check("t4_grant_alternates", int'(ram_load), int'(!prev_load));
            prev_load = ram_load;
        end
        drain("t4_drained");

        // 5: reset with 10 words held discards them
        for (int i = 0; i < 100 && exp_q.size() < 10; i++) begin
            cycle(1'b1, 16'(nxt), 1'b0, 1'b0, acc);
            if (acc) nxt++;
        end
        check("t5_held", exp_q.size(), 10);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, acc);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, acc);
        check("t5_level", int'(level), 0);
        check("t5_out_valid", int'(out_valid), 0);
        check("t5_in_ready", int'(in_ready), 1);
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, acc);
        check("t5_accept", int'(acc), 1);
        for (int i = 0; i < 5 && !out_valid; i++)
            cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        check("t5_first_word", int'(out_data), 16'hBEEF);
        drain("t5_drained");

        // 6: random traffic with occasional resets
        pv = 50;
        pr = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 1000 == 0) begin
                pv = int'($urandom_range(20, 95));
                pr = int'($urandom_range(20, 95));
            end
            cycle(int'($urandom_range(0, 99)) < pv, 16'($urandom),
                  int'($urandom_range(0, 99)) < pr,
                  $urandom_range(0, 1999) == 0, acc);
        end
        drain("t6_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
